regfile_wr_arbiter: RTL and testbench

//  Round-robin write-port arbiter/sequencer for the sCPU register bank built from 4-bit WE-gated registers.

---
 rtl/regfile_wr_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin write-port arbiter for the register bank.
// Picks at most one requester per cycle and drives a registered one-hot
// register write enable, the shared data bus and a one-cycle grant pulse.
//
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   req        per-requester write request (level)
//   req_addr   packed target register, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt        one-cycle grant pulse, one-hot or zero
//   reg_we     one-hot write enable to the register bank
//   reg_d      shared write data to the register bank (holds when idle)
//   wr_count   committed-write counter, wraps at 255
//   prot_err   write-to-r0 pulse (REGFILE_ARB_R0_PROTECT_EN only, else 0)
//
// Build option: define REGFILE_ARB_R0_PROTECT_EN to make register 0 a
// read-only zero register.
module regfile_wr_arbiter #(
   parameter int unsigned NUM_REQ  = 3,
   parameter int unsigned NUM_REGS = 4,
   parameter int unsigned ADDR_W   = 2,
   parameter int unsigned DATA_W   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [NUM_REGS-1:0]         reg_we,
   output logic [DATA_W-1:0]           reg_d,
   output logic [7:0]                  wr_count,
   output logic                        prot_err
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    rr_ptr_nxt;
   logic [NUM_REQ-1:0]  eligible;
   logic                win_valid;
   logic [PTR_W-1:0]    win_idx;
   logic [NUM_REQ-1:0]  win_gnt;
   logic [ADDR_W-1:0]   win_addr;
   logic [DATA_W-1:0]   win_data;
   logic [NUM_REGS-1:0] win_we;
   logic                win_prot;
   int unsigned         cand;

   // Round-robin search from rr_ptr upward; the requester currently holding
   // gnt is masked so it cannot be granted twice in a row on a stale req.
   always_comb begin
      eligible  = req & ~gnt;
      win_valid = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         cand = 32'(rr_ptr) + off;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!win_valid && eligible[PTR_W'(cand)]) begin
            win_valid = 1'b1;
            win_idx   = PTR_W'(cand);
         end
      end
   end

   // Winner payload select, write-enable decode and pointer advance.
   always_comb begin
      win_gnt  = '0;
      win_addr = '0;
      win_data = '0;
      win_we   = '0;
      win_prot = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (32'(win_idx) == i) begin
            win_gnt[i] = win_valid;
            win_addr   = req_addr[i*ADDR_W +: ADDR_W];
            win_data   = req_data[i*DATA_W +: DATA_W];
         end
      end
      // Out-of-range addresses decode to no enable at all.
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         win_we[r] = win_valid && (32'(win_addr) == r);
      end
`ifdef REGFILE_ARB_R0_PROTECT_EN
      if (win_valid && (win_addr == '0)) begin
         win_prot = 1'b1;
         win_we   = '0;
      end
`endif
      if (win_valid && (32'(win_idx) == NUM_REQ - 1)) begin
         rr_ptr_nxt = '0;
      end else if (win_valid) begin
         rr_ptr_nxt = win_idx + PTR_W'(1);
      end else begin
         rr_ptr_nxt = rr_ptr;
      end
   end

   // Output and pointer registers; reset aborts any write in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         gnt      <= '0;
         reg_we   <= '0;
         reg_d    <= '0;
         wr_count <= '0;
         prot_err <= 1'b0;
      end else begin
         rr_ptr   <= rr_ptr_nxt;
         gnt      <= win_gnt;
         reg_we   <= win_we;
         prot_err <= win_prot;
         if (win_valid) reg_d <= win_data;
         if (|win_we) wr_count <= wr_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (3 requesters, 4 x 4-bit registers).
module tb_regfile_wr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] req = '0;
   logic [5:0] req_addr = '0;
   logic [11:0] req_data = '0;
   logic [2:0] gnt;
   logic [3:0] reg_we;
   logic [3:0] reg_d;
   logic [7:0] wr_count;
   logic       prot_err;

   int checks = 0;
   int failures = 0;

   regfile_wr_arbiter #(.NUM_REQ(3), .NUM_REGS(4), .ADDR_W(2), .DATA_W(4)) dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
      .gnt(gnt), .reg_we(reg_we), .reg_d(reg_d), .wr_count(wr_count), .prot_err(prot_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] a, input logic [3:0] d);
      req_addr[i*2 +: 2] = a;
      req_data[i*4 +: 4] = d;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 3'b111;
      set_req(0, 2'd1, 4'h1); set_req(1, 2'd2, 4'h2); set_req(2, 2'd3, 4'h3);
      step(); step();
      checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
      checks++; if (reg_we !== 4'b0000) begin failures++; $display("FAIL reset_we got=%b exp=0000", reg_we); end
      checks++; if (reg_d !== 4'h0) begin failures++; $display("FAIL reset_d got=%h exp=0", reg_d); end
      checks++; if (wr_count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", wr_count); end
      checks++; if (prot_err !== 1'b0) begin failures++; $display("FAIL reset_prot got=%b exp=0", prot_err); end
      rst = 1'b0;
      step();
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL reset_first_gnt got=%b exp=001", gnt); end
      req = '0;
      step();
   endtask

   task automatic test_single_write();
      do_reset();
      req = 3'b010;
      set_req(1, 2'd3, 4'hA);
      step();
      checks++; if (gnt !== 3'b010) begin failures++; $display("FAIL single_gnt got=%b exp=010", gnt); end
      checks++; if (reg_we !== 4'b1000) begin failures++; $display("FAIL single_we got=%b exp=1000", reg_we); end
      checks++; if (reg_d !== 4'hA) begin failures++; $display("FAIL single_d got=%h exp=a", reg_d); end
      checks++; if (wr_count !== 8'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", wr_count); end
      req = '0;
      step();
      checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL idle_gnt got=%b exp=000", gnt); end
      checks++; if (reg_we !== 4'b0000) begin failures++; $display("FAIL idle_we got=%b exp=0000", reg_we); end
      checks++; if (reg_d !== 4'hA) begin failures++; $display("FAIL idle_d_hold got=%h exp=a", reg_d); end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_g [3];
      logic [3:0] exp_we [3];
      logic [3:0] exp_d [3];
      exp_g  = '{3'b001, 3'b010, 3'b100};
      exp_we = '{4'b0010, 4'b0100, 4'b1000};
      exp_d  = '{4'h6, 4'h9, 4'hC};
      do_reset();
      set_req(0, 2'd1, 4'h6); set_req(1, 2'd2, 4'h9); set_req(2, 2'd3, 4'hC);
      req = 3'b111;
      for (int k = 0; k < 3; k++) begin
         step();
         checks++; if (gnt !== exp_g[k]) begin failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", k, gnt, exp_g[k]); end
         checks++; if (reg_we !== exp_we[k]) begin failures++; $display("FAIL rr_we[%0d] got=%b exp=%b", k, reg_we, exp_we[k]); end
         checks++; if (reg_d !== exp_d[k]) begin failures++; $display("FAIL rr_d[%0d] got=%h exp=%h", k, reg_d, exp_d[k]); end
         req = req & ~exp_g[k];
      end
      checks++; if (wr_count !== 8'd3) begin failures++; $display("FAIL rr_count got=%0d exp=3", wr_count); end
   endtask

   task automatic test_fairness();
      logic [2:0] exp_g [4];
      exp_g = '{3'b001, 3'b100, 3'b001, 3'b100};
      do_reset();
      set_req(0, 2'd1, 4'h3); set_req(2, 2'd2, 4'h4);
      req = 3'b101;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (gnt !== exp_g[k]) begin failures++; $display("FAIL fair_gnt[%0d] got=%b exp=%b", k, gnt, exp_g[k]); end
      end
      req = '0;
      checks++; if (wr_count !== 8'd4) begin failures++; $display("FAIL fair_count got=%0d exp=4", wr_count); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_g [4];
      exp_g = '{3'b010, 3'b000, 3'b010, 3'b000};
      do_reset();
      set_req(1, 2'd0, 4'h8);
      req = 3'b010;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++; if (gnt !== exp_g[k]) begin failures++; $display("FAIL b2b_gnt[%0d] got=%b exp=%b", k, gnt, exp_g[k]); end
      end
      req = '0;
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      set_req(1, 2'd2, 4'h7);
      req = 3'b010;
      step();
      checks++; if (reg_we !== 4'b0100) begin failures++; $display("FAIL mid_pre_we got=%b exp=0100", reg_we); end
      #1 rst = 1'b1;
      #1;
      checks++; if (gnt !== 3'b000) begin failures++; $display("FAIL mid_gnt got=%b exp=000", gnt); end
      checks++; if (reg_we !== 4'b0000) begin failures++; $display("FAIL mid_we got=%b exp=0000", reg_we); end
      checks++; if (wr_count !== 8'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", wr_count); end
      step();
      rst = 1'b0;
      set_req(0, 2'd1, 4'h1); set_req(2, 2'd3, 4'h2);
      req = 3'b111;
      step();
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL mid_ptr_gnt got=%b exp=001", gnt); end
      req = '0;
      step();
   endtask

   task automatic test_addr0();
      do_reset();
      set_req(0, 2'd0, 4'h5);
      req = 3'b001;
      step();
      checks++; if (gnt !== 3'b001) begin failures++; $display("FAIL a0_gnt got=%b exp=001", gnt); end
`ifdef REGFILE_ARB_R0_PROTECT_EN
      checks++; if (prot_err !== 1'b1) begin failures++; $display("FAIL a0_prot got=%b exp=1", prot_err); end
      checks++; if (reg_we !== 4'b0000) begin failures++; $display("FAIL a0_we got=%b exp=0000", reg_we); end
      checks++; if (wr_count !== 8'd0) begin failures++; $display("FAIL a0_count got=%0d exp=0", wr_count); end
`else
      checks++; if (prot_err !== 1'b0) begin failures++; $display("FAIL a0_prot got=%b exp=0", prot_err); end
      checks++; if (reg_we !== 4'b0001) begin failures++; $display("FAIL a0_we got=%b exp=0001", reg_we); end
      checks++; if (reg_d !== 4'h5) begin failures++; $display("FAIL a0_d got=%h exp=5", reg_d); end
      checks++; if (wr_count !== 8'd1) begin failures++; $display("FAIL a0_count got=%0d exp=1", wr_count); end
`endif
      req = '0;
      step();
      checks++; if (prot_err !== 1'b0) begin failures++; $display("FAIL a0_prot_clear got=%b exp=0", prot_err); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_fairness();
      test_back_to_back();
      test_reset_mid_grant();
      test_addr0();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
